// File: rtl/output_wrapper.sv
`default_nettype none
// ============================================================================
// Module   : output_wrapper
// Purpose  : Rounds (nearest-even) and packs the sqrt root into an IEEE-754
//            single/double word, delivered over a valid/ready handshake.
//            Optional feature macro: OUTPUT_WRAPPER_EXC_FLAGS_EN
// Revision : 1.0
// ============================================================================
module output_wrapper #(
    parameter int IN_R_SIZE = 55,
    parameter int EXP_SIZE  = 11,
    parameter int OUT_SIZE  = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sqrt_done,
    input  logic [IN_R_SIZE-1:0] in_root,
    input  logic                 rem_nz,
    input  logic [EXP_SIZE-1:0]  in_exp,
    input  logic [2:0]           in_flags,
    input  logic                 in_sign,
    input  logic                 in_type,
    input  logic                 ready,
    output logic                 valid,
    output logic                 busy,
    output logic [OUT_SIZE-1:0]  result,
    output logic                 exc_invalid,
    output logic                 exc_inexact
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [2:0] c_fl_zero = 3'b001;
    localparam logic [2:0] c_fl_inf  = 3'b010;
    localparam logic [2:0] c_fl_nan  = 3'b011;
    localparam logic [2:0] c_fl_serr = 3'b111;

    state_t                r_state, w_next_state;
    logic                  r_captured;
    logic [IN_R_SIZE-1:0]  r_root;
    logic                  r_rem_nz;
    logic [EXP_SIZE-1:0]   r_exp;
    logic [2:0]            r_flags;
    logic                  r_sign;
    logic                  r_type;
    logic [OUT_SIZE-1:0]   r_result;
    logic [OUT_SIZE-1:0]   w_result;
    logic                  w_capture;

    // Inputs land in a capture stage first; the FSM leaves IDLE one edge later.
    assign w_capture = (r_state == IDLE) && sqrt_done && !r_captured;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_captured <= 1'b0;
            r_root     <= '0;
            r_rem_nz   <= 1'b0;
            r_exp      <= '0;
            r_flags    <= '0;
            r_sign     <= 1'b0;
            r_type     <= 1'b0;
            r_result   <= '0;
        end else begin
            r_state    <= w_next_state;
            r_captured <= w_capture;
            if (w_capture) begin
                r_root   <= in_root;
                r_rem_nz <= rem_nz;
                r_exp    <= in_exp;
                r_flags  <= in_flags;
                r_sign   <= in_sign;
                r_type   <= in_type;
            end
            if (r_state == ROUND) begin
                r_result <= w_result;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (r_captured)     w_next_state = ROUND;
            ROUND:                       w_next_state = HOLD;
            HOLD:    if (ready)          w_next_state = IDLE;
            default:                     w_next_state = IDLE;
        endcase
    end

    // Rounding datapath for both precisions
    logic        w_d_guard, w_d_sticky, w_d_up;
    logic        w_s_guard, w_s_sticky, w_s_up;
    logic [53:0] w_d_sum;
    logic [24:0] w_s_sum;
    logic [51:0] w_d_frac;
    logic [22:0] w_s_frac;
    logic [10:0] w_d_exp;
    logic [7:0]  w_s_exp;
    logic        w_guard, w_sticky;

    assign w_d_guard  = r_root[1];
    assign w_d_sticky = r_root[0] | r_rem_nz;
    assign w_d_up     = w_d_guard & (w_d_sticky | r_root[2]);
    assign w_d_sum    = {1'b0, r_root[54:2]} + {53'd0, w_d_up};
    assign w_d_frac   = w_d_sum[53] ? 52'd0 : w_d_sum[51:0];
    assign w_d_exp    = r_exp + {10'd0, w_d_sum[53]};

    assign w_s_guard  = r_root[30];
    assign w_s_sticky = (|r_root[29:0]) | r_rem_nz;
    assign w_s_up     = w_s_guard & (w_s_sticky | r_root[31]);
    assign w_s_sum    = {1'b0, r_root[54:31]} + {24'd0, w_s_up};
    assign w_s_frac   = w_s_sum[24] ? 23'd0 : w_s_sum[22:0];
    assign w_s_exp    = r_exp[7:0] + {7'd0, w_s_sum[24]};

    assign w_guard    = r_type ? w_d_guard  : w_s_guard;
    assign w_sticky   = r_type ? w_d_sticky : w_s_sticky;

    always_comb begin
        w_result = '0;
        case (r_flags)
            c_fl_zero: w_result = r_type ? {r_sign, 63'd0} : {32'd0, r_sign, 31'd0};
            c_fl_inf:  w_result = r_type ? 64'h7FF0000000000000 : 64'h000000007F800000;
            c_fl_nan,
            c_fl_serr: w_result = r_type ? 64'h7FF8000000000000 : 64'h000000007FC00000;
            default:   w_result = r_type ? {1'b0, w_d_exp, w_d_frac}
                                         : {32'd0, 1'b0, w_s_exp, w_s_frac};
        endcase
    end

    assign valid  = (r_state == HOLD);
    assign busy   = (r_state != IDLE);
    assign result = r_result;

`ifdef OUTPUT_WRAPPER_EXC_FLAGS_EN
    logic r_exc_invalid, r_exc_inexact;
    logic w_computed;

    assign w_computed = (r_flags != c_fl_zero) && (r_flags != c_fl_inf) &&
                        (r_flags != c_fl_nan)  && (r_flags != c_fl_serr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_exc_invalid <= 1'b0;
            r_exc_inexact <= 1'b0;
        end else if (r_state == ROUND) begin
            r_exc_invalid <= (r_flags == c_fl_serr);
            r_exc_inexact <= w_computed & (w_guard | w_sticky);
        end
    end

    assign exc_invalid = r_exc_invalid;
    assign exc_inexact = r_exc_inexact;
`else
    logic w_unused_gs;
    assign w_unused_gs = w_guard ^ w_sticky;
    assign exc_invalid = 1'b0;
    assign exc_inexact = 1'b0;
`endif

endmodule
`default_nettype wire
